fetch_sequencer: RTL and testbench

Control FSM that sequences the fetch stage's next-PC mux and IF/ID buffer. Every cycle it decides among four sources: sequential PC, resolved jump/call target, return address, or IVT vector. It boots the core through the reset vector and runs interrupt entry: drain, push return PC, vector load. It sits beside `fetch` and drives its `pc_select`, `index` and `enableBuf` inputs plus the PC write enable and IF/ID flush.

---
 rtl/fetch_pkg.sv | 9 +
 rtl/fetch_sequencer.sv | 120 ++++++++++++
 tb/tb_fetch_sequencer.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared encodings and FSM states for the fetch sequencer.
package fetch_pkg;
  localparam int N_VEC_DEFAULT = 8;
  localparam logic [1:0] PCSEL_SEQ = 2'd0;
  localparam logic [1:0] PCSEL_JMP = 2'd1;
  localparam logic [1:0] PCSEL_RET = 2'd2;
  localparam logic [1:0] PCSEL_IVT = 2'd3;
  typedef enum logic [1:0] {BOOT, RUN, PUSH, VEC} state_e;
endpackage

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: picks the next-PC source each cycle, boots through the reset
// vector and sequences interrupt entry (drain, push return PC, vector load).
module fetch_sequencer
  import fetch_pkg::*;
#(
  parameter int N_VEC       = N_VEC_DEFAULT,
  parameter int RESET_INDEX = 0,
  parameter int PUSH_WORDS  = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     stall,
  input  logic                     jump_valid,
  input  logic                     ret_valid,
  input  logic                     rti,
  input  logic                     int_req,
  input  logic [$clog2(N_VEC)-1:0] int_src,
  input  logic                     mem_busy,
  output logic [1:0]               pc_select,
  output logic [$clog2(N_VEC)-1:0] vec_index,
  output logic                     pc_en,
  output logic                     enableBuf,
  output logic                     flush,
  output logic                     push_req,
  output logic [1:0]               push_word,
  output logic                     int_ack,
  output logic                     int_flag
);
  localparam int VW = $clog2(N_VEC);
  localparam logic [VW-1:0] RST_IDX = VW'(RESET_INDEX);
  localparam logic [1:0] LAST_WORD = 2'(PUSH_WORDS - 1);
  state_e state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [VW-1:0] src_q, src_d;
  logic flag_q, flag_d;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= BOOT;
      cnt_q   <= '0;
      src_q   <= '0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      src_q   <= src_d;
      flag_q  <= flag_d;
    end
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    src_d     = src_q;
    flag_d    = flag_q;
    pc_select = PCSEL_SEQ;
    vec_index = RST_IDX;
    pc_en     = 1'b0;
    enableBuf = 1'b0;
    flush     = 1'b0;
    push_req  = 1'b0;
    push_word = 2'd0;
    int_ack   = 1'b0;
    case (state_q)
      BOOT: begin
        pc_select = PCSEL_IVT;
        pc_en     = 1'b1;
        flush     = 1'b1;
        state_d   = RUN;
      end
      RUN:
        if (ret_valid) begin
          pc_select = PCSEL_RET;
          pc_en     = 1'b1;
          flush     = 1'b1;
          flag_d    = rti ? 1'b0 : flag_q;
        end else if (jump_valid) begin
          pc_select = PCSEL_JMP;
          pc_en     = 1'b1;
          flush     = 1'b1;
        end else if (int_req && !flag_q && !stall) begin
          // PC is held this cycle so it still holds the return address
          flush   = 1'b1;
          src_d   = int_src;
          cnt_d   = 2'd0;
          state_d = PUSH;
        end else if (!stall) begin
          pc_en     = 1'b1;
          enableBuf = 1'b1;
        end
      PUSH: begin
        flush     = 1'b1;
        push_req  = !mem_busy;
        push_word = cnt_q;
        if (push_req) begin
          cnt_d   = (cnt_q == LAST_WORD) ? 2'd0 : cnt_q + 2'd1;
          state_d = (cnt_q == LAST_WORD) ? VEC : PUSH;
        end
      end
      default: begin
        pc_select = PCSEL_IVT;
        vec_index = src_q;
        pc_en     = 1'b1;
        flush     = 1'b1;
        int_ack   = 1'b1;
        flag_d    = 1'b1;
        state_d   = RUN;
      end
    endcase
    // reset values appear on the outputs as soon as rst_n falls
    if (!rst_n) begin
      pc_select = PCSEL_SEQ;
      vec_index = RST_IDX;
      pc_en     = 1'b0;
      enableBuf = 1'b0;
      flush     = 1'b1;
      push_req  = 1'b0;
      push_word = 2'd0;
      int_ack   = 1'b0;
    end
  end
  assign int_flag = flag_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed and random stimulus; a reference model queues the
// expected outputs per cycle and a monitor compares them against the DUT.
module tb_fetch_sequencer;
  localparam int PW = 2;
  localparam int RI = 0;
  logic clk = 1'b0;
  logic rst_n = 1'b0, stall = 1'b0, jump_valid = 1'b0, ret_valid = 1'b0;
  logic rti = 1'b0, int_req = 1'b0, mem_busy = 1'b0;
  logic [2:0] int_src = 3'd0;
  logic [1:0] pc_select, push_word;
  logic [2:0] vec_index;
  logic pc_en, enableBuf, flush, push_req, int_ack, int_flag;

  fetch_sequencer #(.N_VEC(8), .RESET_INDEX(RI), .PUSH_WORDS(PW)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .jump_valid(jump_valid),
    .ret_valid(ret_valid), .rti(rti), .int_req(int_req), .int_src(int_src),
    .mem_busy(mem_busy), .pc_select(pc_select), .vec_index(vec_index),
    .pc_en(pc_en), .enableBuf(enableBuf), .flush(flush), .push_req(push_req),
    .push_word(push_word), .int_ack(int_ack), .int_flag(int_flag)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] sel;
    logic [2:0] vec;
    logic pc_en, eb, flush, preq;
    logic [1:0] pw;
    logic ack, iflag;
  } exp_t;

  exp_t q[$];
  int checks = 0, failures = 0;

  // reference model: boot pending, interrupt entry in progress with words saved so far
  bit m_boot = 1'b1, m_entry = 1'b0, m_flag = 1'b0;
  int m_words = 0;
  logic [2:0] m_src = 3'd0;

  task automatic step(input bit r, input bit st, input bit jv, input bit rv, input bit ri,
                      input bit ir, input logic [2:0] src, input bit mb, input bit gl);
    exp_t e;
    @(posedge clk);
    #2;
    rst_n = r; stall = st; jump_valid = jv; ret_valid = rv; rti = ri;
    int_req = ir; int_src = src; mem_busy = mb;
    if (gl) begin
      rst_n = 1'b0;
      #2 rst_n = 1'b1;
      m_boot = 1'b1; m_entry = 1'b0; m_flag = 1'b0; m_words = 0;
    end
    e = '0;
    e.vec = 3'(RI);
    e.iflag = m_flag;
    if (!r) begin
      e.flush = 1'b1; e.iflag = 1'b0;
      m_boot = 1'b1; m_entry = 1'b0; m_flag = 1'b0; m_words = 0;
    end else if (m_boot) begin
      e.sel = 2'd3; e.pc_en = 1'b1; e.flush = 1'b1;
      m_boot = 1'b0;
    end else if (m_entry && m_words < PW) begin
      e.flush = 1'b1; e.preq = !mb; e.pw = 2'(m_words);
      if (!mb) m_words++;
    end else if (m_entry) begin
      e.sel = 2'd3; e.vec = m_src; e.pc_en = 1'b1; e.flush = 1'b1; e.ack = 1'b1;
      m_flag = 1'b1; m_entry = 1'b0;
    end else if (rv) begin
      e.sel = 2'd2; e.pc_en = 1'b1; e.flush = 1'b1;
      if (ri) m_flag = 1'b0;
    end else if (jv) begin
      e.sel = 2'd1; e.pc_en = 1'b1; e.flush = 1'b1;
    end else if (ir && !m_flag && !st) begin
      e.flush = 1'b1;
      m_src = src; m_entry = 1'b1; m_words = 0;
    end else if (!st) begin
      e.pc_en = 1'b1; e.eb = 1'b1;
    end
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, 3'd0, 0, 0);
  endtask

  initial begin
    exp_t e, a;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        e = q.pop_front();
        a = {pc_select, vec_index, pc_en, enableBuf, flush, push_req, push_word, int_ack, int_flag};
        checks++;
        if (a !== e) begin
          failures++;
          $display("FAIL outputs t=%0t got sel=%0d vec=%0d pc_en=%b eb=%b fl=%b preq=%b pw=%0d ack=%b if=%b exp sel=%0d vec=%0d pc_en=%b eb=%b fl=%b preq=%b pw=%0d ack=%b if=%b",
                   $time, a.sel, a.vec, a.pc_en, a.eb, a.flush, a.preq, a.pw, a.ack, a.iflag,
                   e.sel, e.vec, e.pc_en, e.eb, e.flush, e.preq, e.pw, e.ack, e.iflag);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 3'd0, 0, 0);
    idle(4);
    step(1, 0, 0, 0, 0, 1, 3'd3, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 3'd0, 0, 0);
    for (int i = 0; i < 2; i++) step(1, 0, 0, 0, 0, 1, 3'd6, 0, 0);
    step(1, 0, 0, 1, 1, 1, 3'd5, 0, 0);
    step(1, 0, 0, 0, 0, 1, 3'd5, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 3'd0, 1, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 3'd0, 0, 0);
    step(1, 0, 0, 1, 1, 0, 3'd0, 0, 0);
    step(1, 0, 1, 0, 0, 1, 3'd2, 0, 0);
    step(1, 0, 0, 0, 0, 1, 3'd2, 0, 0);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 0, 3'd0, 0, 0);
    step(1, 0, 0, 1, 1, 0, 3'd0, 0, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0, 0, 1, 3'd7, 0, 0);
    step(1, 0, 0, 0, 0, 1, 3'd7, 0, 0);
    step(1, 0, 0, 0, 0, 0, 3'd0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 3'd0, 0, 1);
    idle(3);
    step(1, 0, 0, 0, 0, 1, 3'd4, 0, 0);
    step(1, 0, 0, 0, 0, 0, 3'd0, 0, 0);
    for (int i = 0; i < 2; i++) step(0, 0, 0, 0, 0, 0, 3'd0, 0, 0);
    idle(3);
    for (int i = 0; i < 3000; i++) begin
      automatic bit rv = ($urandom_range(0, 9) == 0);
      step($urandom_range(0, 199) != 0, $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0,
           rv, rv && $urandom_range(0, 1), $urandom_range(0, 2) == 0, 3'($urandom_range(0, 7)),
           $urandom_range(0, 2) == 0, $urandom_range(0, 299) == 0);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL drain got %0d pending exp 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
